// File: rtl/relay_station_mc.sv
// Multi-channel relay station: LEVEL-deep write/credit pipelines feeding a per-channel FWFT FIFO.
// Optional RELAY_STATION_MC_WATERMARK_EN adds if_max_used, the per-channel peak occupancy since reset.
module relay_station_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 1,
    parameter int DEPTH      = 2,
    parameter int LEVEL      = 2,
    localparam int REAL_DEPTH = DEPTH + 2 * LEVEL,
    localparam int ADDR_WIDTH = (REAL_DEPTH > 2) ? $clog2(REAL_DEPTH) : 1,
    localparam int CNT_WIDTH  = $clog2(REAL_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [CHANNELS-1:0]            if_full_n,
    input  logic                           if_write_ce,
    input  logic [CHANNELS-1:0]            if_write,
    input  logic [CHANNELS*DATA_WIDTH-1:0] if_din,
    output logic [CHANNELS-1:0]            if_empty_n,
    input  logic                           if_read_ce,
    input  logic [CHANNELS-1:0]            if_read,
    output logic [CHANNELS*DATA_WIDTH-1:0] if_dout,
    output logic [CHANNELS*CNT_WIDTH-1:0]  if_used,
    output logic [CHANNELS-1:0]            if_overflow
`ifdef RELAY_STATION_MC_WATERMARK_EN
    ,
    output logic [CHANNELS*CNT_WIDTH-1:0]  if_max_used
`endif
);

    // Handshake: a word enters when if_write & if_write_ce (if_full_n is a LEVEL-delayed credit the
    // producer should honour); a word leaves when if_empty_n & if_read & if_read_ce, head on if_dout.
    localparam logic [CNT_WIDTH-1:0]  DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  REAL_C  = CNT_WIDTH'(REAL_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(REAL_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADR_ONE = ADDR_WIDTH'(1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] din;
        logic                  wr_req;
        logic                  fifo_full_n;
        logic                  arrive;
        logic [DATA_WIDTH-1:0] arrive_data;
        logic                  pop;
        logic                  push;
        logic [CNT_WIDTH-1:0]  used_q, used_d;
        logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
        logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
        logic                  ovf_q, ovf_d;
        logic [DATA_WIDTH-1:0] mem [REAL_DEPTH];

        assign din         = if_din[c*DATA_WIDTH +: DATA_WIDTH];
        assign wr_req      = if_write[c] & if_write_ce;
        assign fifo_full_n = (used_q < DEPTH_C);

        if (LEVEL > 0) begin : g_pipe
            logic [LEVEL-1:0]      v_q, v_d;
            logic [LEVEL-1:0]      f_q, f_d;
            logic [DATA_WIDTH-1:0] d_q [LEVEL];
            logic [DATA_WIDTH-1:0] d_d [LEVEL];

            always_comb begin
                v_d    = '0;
                f_d    = '0;
                v_d[0] = wr_req;
                f_d[0] = fifo_full_n;
                d_d[0] = din;
                for (int k = 1; k < LEVEL; k++) begin
                    v_d[k] = v_q[k-1];
                    f_d[k] = f_q[k-1];
                    d_d[k] = d_q[k-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_q <= '0;
                    f_q <= '1;
                    for (int k = 0; k < LEVEL; k++) d_q[k] <= '0;
                end else begin
                    v_q <= v_d;
                    f_q <= f_d;
                    for (int k = 0; k < LEVEL; k++) d_q[k] <= d_d[k];
                end
            end

            assign arrive       = v_q[LEVEL-1];
            assign arrive_data  = d_q[LEVEL-1];
            assign if_full_n[c] = f_q[LEVEL-1];
        end else begin : g_wire
            assign arrive       = wr_req;
            assign arrive_data  = din;
            assign if_full_n[c] = fifo_full_n;
        end

        // A pop frees the slot the arriving word needs, so push+pop at full is accepted.
        always_comb begin
            pop    = if_read[c] & if_read_ce & (used_q != '0);
            push   = arrive & ((used_q < REAL_C) | pop);
            used_d = used_q;
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            ovf_d  = ovf_q;
            if (push) wptr_d = (wptr_q == LAST_C) ? '0 : wptr_q + ADR_ONE;
            if (pop)  rptr_d = (rptr_q == LAST_C) ? '0 : rptr_q + ADR_ONE;
            if (push && !pop)      used_d = used_q + CNT_ONE;
            else if (pop && !push) used_d = used_q - CNT_ONE;
            if (arrive && !push)   ovf_d  = 1'b1;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                used_q <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                used_q <= used_d;
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                ovf_q  <= ovf_d;
            end
        end

        // Storage carries no reset; if_dout is only meaningful while if_empty_n is high.
        always_ff @(posedge clk) begin
            if (push) mem[wptr_q] <= arrive_data;
        end

        assign if_empty_n[c]                        = (used_q != '0);
        assign if_dout[c*DATA_WIDTH +: DATA_WIDTH]  = mem[rptr_q];
        assign if_used[c*CNT_WIDTH +: CNT_WIDTH]    = used_q;
        assign if_overflow[c]                       = ovf_q;

`ifdef RELAY_STATION_MC_WATERMARK_EN
        logic [CNT_WIDTH-1:0] max_q, max_d;

        always_comb begin
            max_d = max_q;
            if (used_q > max_q) max_d = used_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) max_q <= '0;
            else       max_q <= max_d;
        end

        assign if_max_used[c*CNT_WIDTH +: CNT_WIDTH] = max_q;
`endif
    end

endmodule

// File: tb/tb_relay_station_mc.sv
// Directed bench for relay_station_mc: three instances (LEVEL=2 single channel, LEVEL=3 two channels,
// LEVEL=0 bypass) driven from one linear initial block.
module tb_relay_station_mc;

    logic clk;
    logic reset;
    logic wce;
    logic rce;

    // dut_a: CH=1, LEVEL=2, DEPTH=2 -> REAL_DEPTH=6, CNT_WIDTH=3
    logic        a_full_n, a_write, a_empty_n, a_read, a_ovf;
    logic [31:0] a_din, a_dout;
    logic [2:0]  a_used;
    // dut_b: CH=2, LEVEL=3, DEPTH=2 -> REAL_DEPTH=8, CNT_WIDTH=4
    logic [1:0]  b_full_n, b_write, b_empty_n, b_read, b_ovf;
    logic [63:0] b_din, b_dout;
    logic [7:0]  b_used;
    // dut_c: CH=1, LEVEL=0, DEPTH=2 -> REAL_DEPTH=2, CNT_WIDTH=2
    logic        c_full_n, c_write, c_empty_n, c_read, c_ovf;
    logic [31:0] c_din, c_dout;
    logic [1:0]  c_used;
`ifdef RELAY_STATION_MC_WATERMARK_EN
    logic [2:0]  a_max;
    logic [7:0]  b_max;
    logic [1:0]  c_max;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    relay_station_mc #(.DATA_WIDTH(32), .CHANNELS(1), .DEPTH(2), .LEVEL(2)) dut_a (
        .clk(clk), .reset(reset), .if_full_n(a_full_n), .if_write_ce(wce), .if_write(a_write),
        .if_din(a_din), .if_empty_n(a_empty_n), .if_read_ce(rce), .if_read(a_read),
        .if_dout(a_dout), .if_used(a_used), .if_overflow(a_ovf)
`ifdef RELAY_STATION_MC_WATERMARK_EN
        , .if_max_used(a_max)
`endif
    );

    relay_station_mc #(.DATA_WIDTH(32), .CHANNELS(2), .DEPTH(2), .LEVEL(3)) dut_b (
        .clk(clk), .reset(reset), .if_full_n(b_full_n), .if_write_ce(wce), .if_write(b_write),
        .if_din(b_din), .if_empty_n(b_empty_n), .if_read_ce(rce), .if_read(b_read),
        .if_dout(b_dout), .if_used(b_used), .if_overflow(b_ovf)
`ifdef RELAY_STATION_MC_WATERMARK_EN
        , .if_max_used(b_max)
`endif
    );

    relay_station_mc #(.DATA_WIDTH(32), .CHANNELS(1), .DEPTH(2), .LEVEL(0)) dut_c (
        .clk(clk), .reset(reset), .if_full_n(c_full_n), .if_write_ce(wce), .if_write(c_write),
        .if_din(c_din), .if_empty_n(c_empty_n), .if_read_ce(rce), .if_read(c_read),
        .if_dout(c_dout), .if_used(c_used), .if_overflow(c_ovf)
`ifdef RELAY_STATION_MC_WATERMARK_EN
        , .if_max_used(c_max)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        a_write = 0; a_read = 0; a_din = '0;
        b_write = '0; b_read = '0; b_din = '0;
        c_write = 0; c_read = 0; c_din = '0;
        wce = 1; rce = 1;
    endtask

    // Asserts reset between clock edges and checks the outputs before any edge arrives.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1;
        #1;
        chk({tag, "_a_full_n"}, a_full_n, 1);
        chk({tag, "_a_empty_n"}, a_empty_n, 0);
        chk({tag, "_a_used"}, a_used, 0);
        chk({tag, "_a_ovf"}, a_ovf, 0);
        chk({tag, "_b_full_n"}, b_full_n, 2'b11);
        chk({tag, "_b_empty_n"}, b_empty_n, 2'b00);
        chk({tag, "_b_used"}, b_used, 0);
        chk({tag, "_c_empty_n"}, c_empty_n, 0);
        #2;
        reset = 0;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        int got;
        int sent;
        logic [31:0] exp_w;

        reset = 1;
        idle_inputs();
        tick();
        chk("rst_a_full_n", a_full_n, 1);
        chk("rst_a_empty_n", a_empty_n, 0);
        chk("rst_a_used", a_used, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_b_full_n", b_full_n, 2'b11);
        chk("rst_c_full_n", c_full_n, 1);
        tick();
        reset = 0;
        tick();

        // T1: single write; LEVEL=2 shows at cycle 3, LEVEL=0 at cycle 1
        a_write = 1; a_din = 32'hA5;
        c_write = 1; c_din = 32'h5A;
        tick();
        a_write = 0; c_write = 0;
        chk("t1_c_empty_n_c1", c_empty_n, 1);
        chk("t1_c_dout", c_dout, 32'h5A);
        chk("t1_c_used", c_used, 1);
        chk("t1_a_empty_n_c1", a_empty_n, 0);
        tick();
        chk("t1_a_empty_n_c2", a_empty_n, 0);
        tick();
        chk("t1_a_empty_n_c3", a_empty_n, 1);
        chk("t1_a_dout", a_dout, 32'hA5);
        chk("t1_a_used", a_used, 1);
        // write with write_ce low must be ignored
        c_write = 1; c_din = 32'h77; wce = 0;
        tick();
        c_write = 0; wce = 1;
        chk("t1_c_wce_gate", c_used, 1);
        mid_reset("r1");

        // T2: compliant producer, no reads
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            a_write = a_full_n;
            a_din = cnt;
            if (a_full_n) cnt++;
            tick();
        end
        a_write = 0;
        repeat (3) tick();
        chk("t2_accepted", cnt, 6);
        chk("t2_used", a_used, 6);
        chk("t2_ovf", a_ovf, 0);
        chk("t2_full_n", a_full_n, 0);
        chk("t2_head", a_dout, 0);
`ifdef RELAY_STATION_MC_WATERMARK_EN
        chk("t2_max_used", a_max, 6);
`endif
        mid_reset("r2");

        // T3: producer ignores full_n, 10 writes
        for (int i = 0; i < 10; i++) begin
            a_write = 1;
            a_din = 32'h10 + i;
            tick();
        end
        a_write = 0;
        repeat (4) tick();
        chk("t3_used_sat", a_used, 6);
        chk("t3_ovf", a_ovf, 1);
        chk("t3_full_n", a_full_n, 0);
        a_read = 1; rce = 0;
        tick();
        chk("t3_rce_gate", a_used, 6);
        rce = 1;
        for (int i = 0; i < 6; i++) begin
            chk("t3_order", a_dout, 32'h10 + i);
            tick();
        end
        a_read = 0;
        chk("t3_drained", a_empty_n, 0);
        chk("t3_used_zero", a_used, 0);
        chk("t3_ovf_sticky", a_ovf, 1);
        mid_reset("r3");

        // T4: full FIFO with arrive and pop in the same cycle
        exp_q.delete();
        for (int cyc = 0; cyc < 28; cyc++) begin
            a_write = (cyc < 26);
            a_din = 32'h100 + cyc;
            if (cyc < 26) exp_q.push_back(32'h100 + cyc);
            a_read = (cyc >= 8);
            if (cyc >= 8) begin
                exp_w = exp_q.pop_front();
                chk("t4_used", a_used, 6);
                chk("t4_dout", a_dout, exp_w);
            end
            tick();
        end
        a_write = 0; a_read = 0;
        repeat (3) tick();
        chk("t4_ovf", a_ovf, 0);
        chk("t4_used_end", a_used, 6);
        chk("t4_head_end", a_dout, exp_q.pop_front());
        mid_reset("r4");

        // T5: two channels, ch0 never read, ch1 streams 0..99
        got = 0; sent = 0; cnt = 0;
        b_read = 2'b10;
        for (int cyc = 0; cyc < 600 && got < 100; cyc++) begin
            b_write[0] = b_full_n[0];
            b_din[31:0] = 32'h8000 + cnt;
            if (b_full_n[0]) cnt++;
            b_write[1] = b_full_n[1] && (sent < 100);
            b_din[63:32] = sent;
            if (b_write[1]) sent++;
            if (b_empty_n[1]) begin
                chk("t5_ch1_order", b_dout[63:32], got);
                got++;
            end
            tick();
        end
        b_write = '0; b_read = '0;
        repeat (4) tick();
        chk("t5_ch1_count", got, 100);
        chk("t5_ch0_used", b_used[3:0], 8);
        chk("t5_ch0_full_n", b_full_n[0], 0);
        chk("t5_ch0_head", b_dout[31:0], 32'h8000);
        chk("t5_ch1_used", b_used[7:4], 0);
        chk("t5_ovf", b_ovf, 2'b00);

        // T6: overflow the LEVEL=2 instance, then reset mid-cycle while busy
        for (int i = 0; i < 9; i++) begin
            a_write = 1;
            a_din = i;
            tick();
        end
        a_write = 0;
        repeat (3) tick();
        chk("t6_pre_ovf", a_ovf, 1);
        chk("t6_pre_full_n", a_full_n, 0);
        mid_reset("t6");
        tick();
        chk("t6_post_empty_n", a_empty_n, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
